riscv32_mc_core: RTL
====================

# riscv32_mc_core

Multi-cycle RV32I-subset core that supersedes the fixed four-instruction single-cycle core.
- Adds parametrised instruction and data memory depth, a program-load port, loads and stores, branches and jumps, a run/halt control and a debug register read port.
- Sits at the top of the processor tile, driven by the testbench or the SoC wrapper.
- Executes each instruction through an explicit state machine instead of one combinational cycle.

## Interface
- IMEM_DEPTH, 16, instruction words; power of two, ≥4
- DMEM_DEPTH, 16, data words; power of two, ≥4
- RESET_PC, 32'h0, PC loaded on reset; word aligned
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- run  in  1  1 = execute; 0 = pause at next FETCH
- ld_we  in  1  program-load write strobe
- ld_addr  in  $clog2(IMEM_DEPTH)  program-load word index
- ld_data  in  32  program-load word
- pc_dbg  out  32  current PC
- instr_dbg  out  32  instruction register (IR)
- halted  out  1  core is in HALT
- trap  out  1  halted because of an illegal instruction
- retire  out  1  one-cycle pulse per completed instruction
- dbg_raddr  in  5  debug register index
- dbg_rdata  out  32  combinational read of x[dbg_raddr]; x0 reads 0

## Operation
- Supported instructions: ADDI, ANDI, ORI, XORI, SLTI, ADD, SUB, AND, OR, XOR, SLT, LUI, LW, SW, BEQ, BNE, JAL. ECALL/EBREAK (opcode 1110011) → HALT.
- States:
  - FETCH: IR ← imem[pc index]. Stays in FETCH while run=0.
  - DECODE: A ← x[rs1], B ← x[rs2]; immediate selected by format.
  - EXEC: ALU result latched.
    - Branches resolve here, update PC and retire, then go to FETCH.
    - LW/SW go to MEM; all other instructions go to WB.
  - MEM: SW writes dmem and retires, then FETCH; LW latches the data, then WB.
  - WB: x[rd] written, PC updated, retire pulsed, then FETCH.
  - HALT: terminal state; left only by reset.
- PC update:
  - Default pc+4.
  - Branch taken / JAL: pc + offset, with bits[1:0] forced to 0.
  - JAL writes pc+4 to rd.
- Arithmetic:
  - All operations are 32-bit and wrap modulo 2^32.
  - SLT/SLTI compare signed.
  - I-type immediates are sign-extended from bit 31.
- Addressing:
  - imem index = pc[$clog2(IMEM_DEPTH)+1:2], so PC wraps modulo the memory size.
  - dmem index = addr[$clog2(DMEM_DEPTH)+1:2]; addr bits[1:0] are ignored.
- x0 is hardwired to 0; writes to it are discarded.
- Load port: ld_we is accepted only when the FSM is in FETCH with run=0, or in HALT. It is ignored otherwise.

## Timing
- Reset values:
  - pc = RESET_PC; all registers and dmem = 0; state = FETCH.
  - IR = 32'h00000013; halted = trap = retire = 0.
  - imem is not reset and keeps its contents.
- Cycles per instruction, counted from FETCH entry with run=1:
  - ALU, LUI, JAL: 4
  - LW: 5
  - SW: 4
  - BEQ/BNE: 3
- Register and dmem writes become visible at the clock edge that leaves WB or MEM. retire is high during the cycle that follows that edge.
- reset_n asserted mid-instruction aborts the instruction immediately. No partial register or dmem write may occur after the asserting edge.
- run deasserted outside FETCH: the current instruction completes, then the core pauses in FETCH.
- halted rises in the cycle after the HALT transition and holds until reset.

## Configuration
- RISCV32_MC_ILLEGAL_TRAP_EN:
  - Defined: any unsupported opcode/funct in DECODE → HALT with trap=1; no state update.
  - Undefined: the instruction executes as a NOP (retires, pc+4) and trap is tied to 0.

## Structure
- Package riscv32_pkg holds:
  - opcode constants, funct3/funct7 constants
  - the FSM state enum
  - the ALU operation enum
  - the NOP encoding
- One sub-module riscv32_alu (combinational: op, a, b → result, zero). All sequencing stays in the core.

## Test plan
- Load addi x1,x0,10; addi x2,x0,20; add x3,x1,x2; sub x4,x2,x1, then raise run → x1=10, x2=20, x3=30, x4=10 after 16 cycles with exactly 4 retire pulses.
- sw x3,8(x0); lw x5,8(x0) → dmem[2]=30 and x5=30; the LW takes 5 cycles.
- Countdown loop (addi x1,x0,3; addi x1,x1,-1; bne x1,x0,-4; ecall) → x1=0, halted=1, trap=0, pc stays at the ecall address.
- Assert reset_n during EXEC of add x3 → all registers read 0, pc=RESET_PC, and imem contents are retained.
- Program addi x0,x0,5 and jal x0,0 at the IMEM_DEPTH−1 location → x0 reads 0, and the PC wrap index stays within range.
- Opcode 7'h7F → with the macro: halted=1, trap=1; without it: retire pulse and pc+4.

Source files
------------

// File: rtl/riscv32_pkg.sv
// Shared definitions for the multi-cycle RV32I-subset core.
// Holds the opcode/funct3/funct7 constants, the FSM state enum, the ALU
// operation enum, the canonical NOP encoding and small decode helpers.
package riscv32_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_PASSB
  } alu_op_t;

  // funct3 values shared by OP and OP-IMM that this core implements
  function automatic logic f3_supported(input logic [2:0] f3);
    return (f3 == F3_ADD) || (f3 == F3_SLT) || (f3 == F3_XOR) ||
           (f3 == F3_OR)  || (f3 == F3_AND);
  endfunction

  function automatic alu_op_t f3_alu_op(input logic [2:0] f3);
    case (f3)
      F3_SLT:  return ALU_SLT;
      F3_XOR:  return ALU_XOR;
      F3_OR:   return ALU_OR;
      F3_AND:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/riscv32_alu.sv
// Combinational ALU for the multi-cycle core.
// Ports: op (operation select), a/b (32-bit operands),
//        result (32-bit, wraps mod 2^32), zero (result == 0).
module riscv32_alu
  import riscv32_pkg::*;
(
  input  alu_op_t     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        zero
);

  always_comb begin
    result = 32'h0;
    case (op)
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_XOR:   result = a ^ b;
      ALU_SLT:   result = {31'h0, $signed(a) < $signed(b)};
      ALU_PASSB: result = b;
      default:   result = 32'h0;
    endcase
  end

  assign zero = (result == 32'h0);

endmodule

// File: rtl/riscv32_mc_core.sv
// Multi-cycle RV32I-subset core: FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
// Ports: clk/reset_n (async active-low), run (pause at FETCH when low),
//        ld_we/ld_addr/ld_data (program load, accepted in FETCH with run=0
//        or in HALT), pc_dbg/instr_dbg (PC and IR), halted, trap, retire
//        (one pulse per completed instruction), dbg_raddr/dbg_rdata
//        (combinational register read, x0 reads 0).
// Build option: define RISCV32_MC_ILLEGAL_TRAP_EN to halt with trap=1 on an
// unsupported instruction; otherwise such instructions retire as NOPs.
module riscv32_mc_core
  import riscv32_pkg::*;
#(
  parameter int          IMEM_DEPTH = 16,
  parameter int          DMEM_DEPTH = 16,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          run,
  input  logic                          ld_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] ld_addr,
  input  logic [31:0]                   ld_data,
  output logic [31:0]                   pc_dbg,
  output logic [31:0]                   instr_dbg,
  output logic                          halted,
  output logic                          trap,
  output logic                          retire,
  input  logic [4:0]                    dbg_raddr,
  output logic [31:0]                   dbg_rdata
);

  localparam int IW = $clog2(IMEM_DEPTH);
  localparam int DW = $clog2(DMEM_DEPTH);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
  logic [31:0] res_q, res_d, npc_q, npc_d, mdr_q, mdr_d;
  logic        retire_q, retire_d, trap_q, trap_d;

  logic [31:0] imem_q [IMEM_DEPTH];
  logic [31:0] rf_q   [32];
  logic [31:0] dmem_q [DMEM_DEPTH];
  logic        imem_we, rf_we, dmem_we;

  // Instruction fields (IR is stable from DECODE until the next FETCH)
  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign f3     = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign f7     = ir_q[31:25];
  assign imm_i  = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s  = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b  = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_u  = {ir_q[31:12], 12'h0};
  assign imm_j  = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

  alu_op_t     alu_op;
  logic [31:0] imm;
  logic use_imm, wr_rd, is_load, is_store, is_branch, is_jal, is_sys, illegal;

  always_comb begin
    alu_op = ALU_ADD; use_imm = 1'b0; imm = imm_i; wr_rd = 1'b0;
    is_load = 1'b0; is_store = 1'b0; is_branch = 1'b0; is_jal = 1'b0;
    is_sys = 1'b0; illegal = 1'b0;
    case (opcode)
      OPC_OP_IMM:
        if (f3_supported(f3)) begin
          alu_op = f3_alu_op(f3); use_imm = 1'b1; wr_rd = 1'b1;
        end else illegal = 1'b1;
      OPC_OP:
        if (f7 == F7_BASE && f3_supported(f3)) begin
          alu_op = f3_alu_op(f3); wr_rd = 1'b1;
        end else if (f7 == F7_SUB && f3 == F3_ADD) begin
          alu_op = ALU_SUB; wr_rd = 1'b1;
        end else illegal = 1'b1;
      OPC_LUI: begin
        alu_op = ALU_PASSB; use_imm = 1'b1; imm = imm_u; wr_rd = 1'b1;
      end
      OPC_LOAD:
        if (f3 == F3_LW) begin
          use_imm = 1'b1; is_load = 1'b1; wr_rd = 1'b1;
        end else illegal = 1'b1;
      OPC_STORE:
        if (f3 == F3_SW) begin
          use_imm = 1'b1; imm = imm_s; is_store = 1'b1;
        end else illegal = 1'b1;
      OPC_BRANCH:
        if (f3 == F3_BEQ || f3 == F3_BNE) begin
          alu_op = ALU_SUB; imm = imm_b; is_branch = 1'b1;
        end else illegal = 1'b1;
      OPC_JAL: begin
        imm = imm_j; is_jal = 1'b1; wr_rd = 1'b1;
      end
      OPC_SYSTEM: is_sys = 1'b1;
      default:    illegal = 1'b1;
    endcase
  end

  logic [31:0] alu_res, pc_plus4, pc_target;
  logic        alu_zero, br_taken;

  riscv32_alu u_alu (
    .op     (alu_op),
    .a      (a_q),
    .b      (use_imm ? imm : b_q),
    .result (alu_res),
    .zero   (alu_zero)
  );

  assign pc_plus4  = pc_q + 32'd4;
  assign pc_target = {pc_q[31:2] + imm[31:2], 2'b00};
  assign br_taken  = (f3 == F3_BEQ) ? alu_zero : !alu_zero;

  always_comb begin
    state_d = state_q; pc_d = pc_q; ir_d = ir_q; a_d = a_q; b_d = b_q;
    res_d = res_q; npc_d = npc_q; mdr_d = mdr_q;
    retire_d = 1'b0; trap_d = trap_q;
    rf_we = 1'b0; dmem_we = 1'b0;
    imem_we = ld_we && ((state_q == S_FETCH && !run) || state_q == S_HALT);
    case (state_q)
      S_FETCH:
        if (run) begin
          ir_d    = imem_q[pc_q[IW+1:2]];
          state_d = S_DECODE;
        end
      S_DECODE: begin
        a_d = rf_q[rs1];
        b_d = rf_q[rs2];
        if (is_sys) begin
          state_d = S_HALT;
        end else if (illegal) begin
`ifdef RISCV32_MC_ILLEGAL_TRAP_EN
          state_d = S_HALT;
          trap_d  = 1'b1;
`else
          // All decode flags are clear, so it flows through as a NOP
          state_d = S_EXEC;
`endif
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        res_d = is_jal ? pc_plus4 : alu_res;
        npc_d = is_jal ? pc_target : pc_plus4;
        if (is_branch) begin
          pc_d     = br_taken ? pc_target : pc_plus4;
          retire_d = 1'b1;
          state_d  = S_FETCH;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM:
        if (is_store) begin
          dmem_we  = 1'b1;
          pc_d     = npc_q;
          retire_d = 1'b1;
          state_d  = S_FETCH;
        end else begin
          mdr_d   = dmem_q[res_q[DW+1:2]];
          state_d = S_WB;
        end
      S_WB: begin
        rf_we    = wr_rd && (rd != 5'd0);
        pc_d     = npc_q;
        retire_d = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= NOP_INSTR;
      a_q      <= 32'h0;
      b_q      <= 32'h0;
      res_q    <= 32'h0;
      npc_q    <= 32'h0;
      mdr_q    <= 32'h0;
      retire_q <= 1'b0;
      trap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      npc_q    <= npc_d;
      mdr_q    <= mdr_d;
      retire_q <= retire_d;
      trap_q   <= trap_d;
    end
  end

  // Program memory survives reset so a loaded program can be re-run
  always_ff @(posedge clk) begin
    if (imem_we) imem_q[ld_addr] <= ld_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'h0;
    end else if (rf_we) begin
      rf_q[rd] <= is_load ? mdr_q : res_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DMEM_DEPTH; i++) dmem_q[i] <= 32'h0;
    end else if (dmem_we) begin
      dmem_q[res_q[DW+1:2]] <= b_q;
    end
  end

  assign pc_dbg    = pc_q;
  assign instr_dbg = ir_q;
  assign halted    = (state_q == S_HALT);
  assign trap      = trap_q;
  assign retire    = retire_q;
  assign dbg_rdata = (dbg_raddr == 5'd0) ? 32'h0 : rf_q[dbg_raddr];

endmodule
